// File: rtl/irq_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// bwzz_irq_pkg
//   Shared definitions for the BWZZ interrupt conditioner: dispatch FSM
//   state encoding and the fixed widths of the dispatch timer and the
//   source-id output.
// ---------------------------------------------------------------------------
package bwzz_irq_pkg;

    // Dispatch FSM: IDLE waits for an enabled pending source, ASSERT drives
    // the interrupt pulse, HOLDOFF keeps the core quiet while it finishes
    // its injection sequence.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

    // Shared down-counter used for both pulse length and hold-off window.
    localparam int CNT_BITS = 8;

    // irqId is always presented at this width, zero-extended.
    localparam int ID_W = 3;

endpackage

// File: rtl/irq_conditioner_sync.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
//   Per-source synchroniser plus rising-edge detector. An asynchronous level
//   request passes through SYNC_STAGES flops; one more history flop remembers
//   the previous synchronised value so a held level yields a single edge.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, clears the whole chain
//   raw    : asynchronous level request
//   rise   : one-cycle pulse when the synchronised request goes 0 -> 1
// ---------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_conditioner.sv
// ---------------------------------------------------------------------------
// irq_conditioner
//   Conditions NUM_SRC external interrupt requests into the single-bit
//   interrupt input of the BWZZ core. Each request is synchronised and
//   edge-detected, latched as pending, and dispatched one at a time by fixed
//   priority (lowest index wins) as a PULSE_LEN-cycle pulse followed by a
//   HOLDOFF_CYCLES-cycle quiet window.
//
// Ports
//   clk          : rising-edge clock shared with the core
//   reset        : synchronous active-high reset
//   irqRaw       : asynchronous level requests, active-high
//   irqMask      : 1 = source may be dispatched (pending latches regardless)
//   clearPending : one-cycle strobes dropping pending bits
//   interrupt    : registered pulse to the core
//   irqId        : index of the last dispatched source, held until the next
//   pending      : registered pending vector
//   busy         : registered, high while in ASSERT or HOLDOFF
//   droppedCount : saturating count of cycles with an edge lost to an
//                  already-pending source
// ---------------------------------------------------------------------------
module irq_conditioner
    import bwzz_irq_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int PULSE_LEN      = 1,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irqRaw,
    input  logic [NUM_SRC-1:0] irqMask,
    input  logic [NUM_SRC-1:0] clearPending,
    output logic               interrupt,
    output logic [ID_W-1:0]    irqId,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic [CNT_W-1:0]   droppedCount
);

    // Timer reload values. The counter counts down to zero inclusive, so a
    // window of L cycles loads L-1.
    localparam logic [CNT_BITS-1:0] PULSE_LOAD = CNT_BITS'(PULSE_LEN - 1);
    localparam logic [CNT_BITS-1:0] HOLD_LOAD  =
        CNT_BITS'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

    // ------------------------------------------------------------------
    // Per-source synchroniser and edge detector
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] rise;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .raw   (irqRaw[i]),
            .rise  (rise[i])
        );
    end

    // ------------------------------------------------------------------
    // Fixed-priority select: lowest enabled pending index
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] req;
    logic               any_req;
    logic [ID_W-1:0]    sel_idx;

    assign req     = pending & irqMask;
    assign any_req = |req;

    always_comb begin
        sel_idx = '0;
        // Scan high to low so the lowest set index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) sel_idx = ID_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    irq_state_t          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                interrupt_d;
    logic [ID_W-1:0]     irq_id_d;
    logic                dispatch;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        interrupt_d = interrupt;
        irq_id_d    = irqId;
        dispatch    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    dispatch    = 1'b1;
                    interrupt_d = 1'b1;
                    irq_id_d    = sel_idx;
                    cnt_d       = PULSE_LOAD;
                    state_d     = ASSERT;
                end
            end

            ASSERT: begin
                if (cnt_q == '0) begin
                    interrupt_d = 1'b0;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = HOLDOFF;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            HOLDOFF: begin
                // Entering IDLE never dispatches on the same edge; the next
                // request is evaluated from IDLE one cycle later.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                interrupt_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending update: edge > clearPending > dispatch-clear > hold
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] pending_d;

    always_comb begin
        pending_d = pending;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rise[i]) begin
                pending_d[i] = 1'b1;
            end else if (clearPending[i]) begin
                pending_d[i] = 1'b0;
            end else if (dispatch && (sel_idx == ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dropped-edge counter: one increment per cycle however many sources
    // collide, saturating at all-ones.
    // ------------------------------------------------------------------
    logic             drop_hit;
    logic [CNT_W-1:0] dropped_d;

    assign drop_hit = |(rise & pending);

    always_comb begin
        dropped_d = droppedCount;
        if (drop_hit && (droppedCount != {CNT_W{1'b1}})) begin
            dropped_d = droppedCount + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            interrupt    <= 1'b0;
            irqId        <= '0;
            pending      <= '0;
            busy         <= 1'b0;
            droppedCount <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            interrupt    <= interrupt_d;
            irqId        <= irq_id_d;
            pending      <= pending_d;
            busy         <= (state_d != IDLE);
            droppedCount <= dropped_d;
        end
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// ---------------------------------------------------------------------------
// tb_irq_conditioner
//   Directed scenarios plus a randomized run checked against a behavioural
//   model. The model describes timing in terms of when the last pulse began
//   and the earliest edge at which the next dispatch may occur, and treats
//   the synchroniser as a pure sample delay line.
//   A second instance with PULSE_LEN=4 covers reset in the middle of a pulse.
// ---------------------------------------------------------------------------
module tb_irq_conditioner;

    localparam int N = 4;
    localparam int S = 2;
    localparam int P = 1;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         reset4 = 1'b1;
    logic [N-1:0] irqRaw = '0;
    logic [N-1:0] irqMask = '0;
    logic [N-1:0] clearPending = '0;

    logic         interrupt, busy;
    logic [2:0]   irqId;
    logic [N-1:0] pending;
    logic [7:0]   droppedCount;

    logic         interrupt4, busy4;
    logic [2:0]   irqId4;
    logic [N-1:0] pending4;
    logic [7:0]   droppedCount4;

    int errs = 0;
    int checks = 0;

    irq_conditioner #(
        .NUM_SRC(N), .SYNC_STAGES(S), .PULSE_LEN(P), .HOLDOFF_CYCLES(H), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .irqRaw(irqRaw), .irqMask(irqMask),
        .clearPending(clearPending), .interrupt(interrupt), .irqId(irqId),
        .pending(pending), .busy(busy), .droppedCount(droppedCount)
    );

    irq_conditioner #(
        .NUM_SRC(N), .SYNC_STAGES(S), .PULSE_LEN(4), .HOLDOFF_CYCLES(H), .CNT_W(8)
    ) dut4 (
        .clk(clk), .reset(reset4), .irqRaw(irqRaw), .irqMask(irqMask),
        .clearPending(clearPending), .interrupt(interrupt4), .irqId(irqId4),
        .pending(pending4), .busy(busy4), .droppedCount(droppedCount4)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model (for dut)
    // ------------------------------------------------------------------
    logic [N-1:0] m_q [0:S];   // m_q[0] = raw sampled at the latest edge
    logic [N-1:0] m_pend = '0;
    int           m_drop = 0;
    logic [2:0]   m_id = '0;
    int           cyc = 0;
    int           t0 = -1000;      // edge at which the last pulse began
    int           free_at = 0;     // earliest edge a new dispatch may occur

    // Advance model by one edge using the inputs currently applied, then let
    // the DUT take the same edge and settle.
    task automatic tick();
        logic [N-1:0] rise, cand, np;
        int k;
        cyc++;
        k = -1;
        if (reset) begin
            m_pend  = '0;
            m_drop  = 0;
            m_id    = '0;
            t0      = -1000;
            free_at = cyc + 1;
            for (int j = 0; j <= S; j++) m_q[j] = '0;
        end else begin
            rise = m_q[S-1] & ~m_q[S];
            cand = m_pend & irqMask;
            if (cyc >= free_at && cand != '0) begin
                for (int i = N - 1; i >= 0; i--) if (cand[i]) k = i;
                t0      = cyc;
                free_at = cyc + P + H + 1;
                m_id    = 3'(k);
            end
            if ((rise & m_pend) != '0 && m_drop < 255) m_drop++;
            np = m_pend;
            for (int i = 0; i < N; i++) begin
                if (rise[i]) np[i] = 1'b1;
                else if (clearPending[i]) np[i] = 1'b0;
                else if (i == k) np[i] = 1'b0;
            end
            m_pend = np;
            for (int j = S; j > 0; j--) m_q[j] = m_q[j-1];
            m_q[0] = irqRaw;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irqRaw = '0;
        clearPending = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        reset4 = 1'b1;
        irqRaw = 4'b1111;
        irqMask = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({interrupt, irqId, pending, busy, droppedCount} !== '0) begin
                errs++;
                $display("FAIL reset_outputs cycle %0d: int=%b id=%0d pend=%b busy=%b drop=%0d, required all 0",
                         c, interrupt, irqId, pending, busy, droppedCount);
            end
        end
        reset = 1'b0;
        reset4 = 1'b0;
        tick();
        tick();
        checks++;
        if (pending !== 4'b0000) begin
            errs++;
            $display("FAIL reset_pending_early: got %b, required 0000", pending);
        end
        tick();
        checks++;
        if (pending !== 4'b1111) begin
            errs++;
            $display("FAIL reset_pending_latency: got %b, required 1111", pending);
        end
    endtask

    task automatic test_single();
        int nbusy;
        do_reset();
        irqMask = 4'b1111;
        tick();
        irqRaw = 4'b0100;
        tick();
        tick();
        tick();
        checks++;
        if (pending !== 4'b0100 || interrupt !== 1'b0) begin
            errs++;
            $display("FAIL single_pending: pend=%b int=%b, required 0100/0", pending, interrupt);
        end
        tick();
        checks++;
        if (interrupt !== 1'b1 || irqId !== 3'd2 || pending[2] !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_pulse: int=%b id=%0d pend=%b busy=%b, required 1/2/x0xx/1",
                     interrupt, irqId, pending, busy);
        end
        nbusy = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (busy === 1'b1 && interrupt === 1'b0) nbusy++;
        end
        tick();
        checks++;
        if (nbusy != 9 || busy !== 1'b0) begin
            errs++;
            $display("FAIL single_busy_window: busy cycles=%0d busy_after=%b, required 9/0", nbusy, busy);
        end
        irqRaw = '0;
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        irqMask = 4'b1111;
        irqRaw = 4'b1010;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (interrupt !== 1'b1 || irqId !== 3'd1) begin
            errs++;
            $display("FAIL prio_first: int=%b id=%0d, required 1/1", interrupt, irqId);
        end
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            n++;
            if (interrupt === 1'b1) break;
        end
        checks++;
        if (n != 10 || interrupt !== 1'b1 || irqId !== 3'd3) begin
            errs++;
            $display("FAIL prio_second: spacing=%0d int=%b id=%0d, required 10/1/3", n, interrupt, irqId);
        end
        checks++;
        if (pending !== 4'b0000) begin
            errs++;
            $display("FAIL prio_pending_drained: got %b, required 0000", pending);
        end
        irqRaw = '0;
    endtask

    task automatic test_mask_clear();
        logic saw;
        do_reset();
        irqMask = 4'b0000;
        irqRaw = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (pending !== 4'b0001) begin
            errs++;
            $display("FAIL mask_latch: pend=%b, required 0001", pending);
        end
        saw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            saw |= interrupt;
        end
        checks++;
        if (saw !== 1'b0) begin
            errs++;
            $display("FAIL mask_no_pulse: saw interrupt=%b, required 0", saw);
        end
        clearPending = 4'b0001;
        tick();
        clearPending = '0;
        checks++;
        if (pending !== 4'b0000) begin
            errs++;
            $display("FAIL clear_pending: pend=%b, required 0000", pending);
        end
        irqMask = 4'b1111;
        saw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            saw |= interrupt;
        end
        checks++;
        if (saw !== 1'b0) begin
            errs++;
            $display("FAIL cleared_never_dispatched: saw interrupt=%b, required 0", saw);
        end
        irqRaw = '0;
    endtask

    task automatic test_drop_collision();
        do_reset();
        irqMask = 4'b0000;
        for (int r = 0; r < 3; r++) begin
            irqRaw = 4'b0100;
            tick();
            tick();
            irqRaw = 4'b0000;
            tick();
            tick();
        end
        tick();
        tick();
        tick();
        checks++;
        if (droppedCount !== 8'd2 || pending !== 4'b0100) begin
            errs++;
            $display("FAIL drop_count: drop=%0d pend=%b, required 2/0100", droppedCount, pending);
        end
        // Edge reaches pending on the third edge after raw rises; strobe
        // clearPending on exactly that edge.
        irqRaw = 4'b0100;
        tick();
        tick();
        clearPending = 4'b0100;
        tick();
        clearPending = '0;
        checks++;
        if (pending !== 4'b0100 || droppedCount !== 8'd3) begin
            errs++;
            $display("FAIL edge_beats_clear: pend=%b drop=%0d, required 0100/3", pending, droppedCount);
        end
        irqRaw = '0;
    endtask

    task automatic test_reset_mid_assert();
        logic saw;
        reset4 = 1'b1;
        irqRaw = '0;
        irqMask = 4'b1111;
        tick();
        tick();
        reset4 = 1'b0;
        irqRaw = 4'b0010;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (interrupt4 !== 1'b1 || irqId4 !== 3'd1 || busy4 !== 1'b1) begin
            errs++;
            $display("FAIL p4_pulse_start: int=%b id=%0d busy=%b, required 1/1/1", interrupt4, irqId4, busy4);
        end
        reset4 = 1'b1;
        irqRaw = '0;
        tick();
        reset4 = 1'b0;
        checks++;
        if ({interrupt4, irqId4, pending4, busy4, droppedCount4} !== '0) begin
            errs++;
            $display("FAIL p4_reset_abort: int=%b id=%0d pend=%b busy=%b, required all 0",
                     interrupt4, irqId4, pending4, busy4);
        end
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            saw |= interrupt4 | busy4;
        end
        checks++;
        if (saw !== 1'b0) begin
            errs++;
            $display("FAIL p4_no_replay: saw int/busy=%b, required 0", saw);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        irqMask = 4'($urandom);
        bad = 0;
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) irqRaw[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) irqMask = 4'($urandom);
            clearPending = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, N-1)) : 4'b0;
            tick();
            checks++;
            if (interrupt !== (cyc >= t0 && cyc < t0 + P) ||
                busy !== (cyc >= t0 && cyc < t0 + P + H) ||
                irqId !== m_id || pending !== m_pend || droppedCount !== 8'(m_drop)) begin
                errs++;
                if (bad < 10)
                    $display("FAIL random cyc %0d: int=%b busy=%b id=%0d pend=%b drop=%0d, required int=%b busy=%b id=%0d pend=%b drop=%0d",
                             cyc, interrupt, busy, irqId, pending, droppedCount,
                             (cyc >= t0 && cyc < t0 + P), (cyc >= t0 && cyc < t0 + P + H),
                             m_id, m_pend, m_drop);
                bad++;
            end
        end
        reset = 1'b0;
        clearPending = '0;
    endtask

    initial begin
        for (int j = 0; j <= S; j++) m_q[j] = '0;
        test_reset();
        test_single();
        test_priority();
        test_mask_clear();
        test_drop_collision();
        test_reset_mid_assert();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/irq_conditioner.md
Name: irq_conditioner

Overview:
- Conditions external interrupt sources into the single-bit `interrupt` input of the BWZZ processor core.
- Per source: synchronises the raw request, detects its rising edge, and latches it as pending.
- Picks one enabled pending source at a time by fixed priority and drives a fixed-length `interrupt` pulse.
- Enforces a hold-off window after each pulse so the core's interrupt-injection sequence (push PC, push flags, jump) finishes before the next request.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- SYNC_STAGES, 2, synchroniser flops per source (>=2).
- PULSE_LEN, 1, cycles `interrupt` stays high per dispatch (1..15).
- HOLDOFF_CYCLES, 8, cycles after pulse end before the next dispatch is allowed (0..255).
- CNT_W, 8, width of the dropped-edge counter.

Ports:
- clk, in, 1: rising-edge clock, shared with the core.
- reset, in, 1: synchronous active-high reset.
- irqRaw, in, NUM_SRC: asynchronous level requests, active-high.
- irqMask, in, NUM_SRC: 1 = source enabled for dispatch.
- clearPending, in, NUM_SRC: one-cycle strobes that drop pending bits.
- interrupt, out, 1: registered pulse to the core.
- irqId, out, 3: index of the source last dispatched; held until the next dispatch.
- pending, out, NUM_SRC: registered pending vector.
- busy, out, 1: high in ASSERT and HOLDOFF states.
- droppedCount, out, CNT_W: saturating count of edges lost to an already-set pending bit.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset response (the edge on which reset=1):
  - all synchroniser flops, edge-history flops and `pending` go to 0;
  - `interrupt`=0, `irqId`=0, `busy`=0, `droppedCount`=0;
  - FSM goes to IDLE and the counter to 0.
- Reset mid-pulse or mid-holdoff aborts immediately; nothing is replayed.
- Synchroniser: SYNC_STAGES-flop chain per source, then one history flop.
  - edge[i] = syncOut[i] & ~hist[i].
  - A level held high produces exactly one edge.
- Pending update, per bit, in priority order:
  1. edge → set;
  2. else clearPending → clear;
  3. else dispatch-clear → clear;
  4. else hold.
  - Edge beats clear on the same cycle.
- Drop counting: edge[i] while pending[i] is already 1 increments `droppedCount` once per cycle, even if several sources drop together. The counter saturates at all-ones.
- Masked sources still latch pending; they dispatch only once unmasked.
- FSM IDLE:
  - If any (pending & irqMask) bit is set, select the lowest set index k and register interrupt=1, irqId=k.
  - Clear pending[k] on the same edge.
  - Load counter with PULSE_LEN-1 and go to ASSERT.
- FSM ASSERT: `interrupt` stays 1.
  - Counter==0: interrupt=0, load HOLDOFF_CYCLES-1, go to HOLDOFF.
  - If HOLDOFF_CYCLES==0, go straight to IDLE instead.
  - Otherwise decrement the counter.
- FSM HOLDOFF: `interrupt` stays 0. Counter==0 → go to IDLE; otherwise decrement.
- No dispatch can occur on the edge that enters IDLE. Minimum spacing between pulse starts is PULSE_LEN + HOLDOFF_CYCLES + 1 cycles.
- Latency: with irqRaw rising before edge N, the source idle and SYNC_STAGES=2:
  - s1 set at N, s2 at N+1, pending at N+2, interrupt rises at edge N+3.
- A pending bit cleared via clearPending before dispatch is never dispatched.
- `busy` is a registered decode of the state: 1 in ASSERT and HOLDOFF.
- Widths: counter is 8 bits; `irqId` is zero-extended to 3 bits.

Decomposition:
- Shared package `bwzz_irq_pkg`: FSM state enum (IDLE, ASSERT, HOLDOFF), counter width constant, irqId width constant.
- One sub-module `irq_sync_edge`: per-source synchroniser plus edge detector, instantiated NUM_SRC times.
- Priority select, pending register, counters and FSM live in the top module.

Test Plan:
- Reset: hold reset 3 cycles with irqRaw=4'b1111 → all outputs 0 at every reset edge; pending=4'b1111 two edges after reset falls.
- Single source: mask=4'b1111, irqRaw[2] rises before edge 10 → interrupt=1 only after edge 13, irqId=2, pending[2]=0 at 13; busy stays high for edges 13..21 (1+8 cycles).
- Priority and holdoff: edges on sources 3 and 1 in the same cycle → first pulse irqId=1; second pulse irqId=3 exactly 10 cycles later.
- Mask and clear:
  - source 0 edge with mask=0 → pending[0]=1, no pulse;
  - clearPending[0] strobed → pending[0]=0;
  - mask then set to 1 → no pulse.
- Drop count and collision: 3 rising edges on source 2 while masked → droppedCount=2. Edge and clearPending on the same cycle → pending stays 1.
- Reset mid-ASSERT with PULSE_LEN=4: reset on the 2nd pulse cycle → interrupt=0 on that edge, FSM back in IDLE, no replay.
